dmem_store_unit: RTL and testbench

- Store-side counterpart of the register-file load path. The register file extracts and extends bytes for lb/lbu; this block formats sb/sh/sw data into byte lanes with byte enables.
- It buffers stores in a small FIFO and issues them to the word-wide data memory over a req/ack handshake.
- It flags misaligned stores and reports load-after-store hazards to the pipeline.
- It sits between the EX/MEM stage and the data memory.

---
 rtl/dmem_store_unit_pkg.sv | 27 ++
 rtl/dmem_store_unit_store_lane_fmt.sv | 40 ++++
 rtl/dmem_store_unit.sv | 178 +++++++++++++++++
 tb/tb_dmem_store_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_store_unit_pkg.sv
// Purpose : shared types for the data-memory store path (op codes, issue FSM, entry lane record).
// Latency : n/a (types only).
// Backpressure: n/a.
package dmem_store_unit_pkg;

    // Store op encoding as presented by EX/MEM; ST_NONE never enqueues.
    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_SB   = 2'b01,
        ST_SH   = 2'b10,
        ST_SW   = 2'b11
    } st_op_e;

    // Issue FSM: IDLE waits for a queued store, ISSUE holds mem_req until ack.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sb_state_e;

    // Lane-formatted part of a buffer entry; the word address is kept
    // alongside it because its width follows the AW parameter.
    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
    } st_lane_t;

endpackage

// File: rtl/dmem_store_unit_store_lane_fmt.sv
// Purpose : formats sb/sh/sw data into 32-bit byte lanes with byte enables and flags misalignment.
// Latency : combinational.
// Backpressure: none (pure function of inputs).
// Ports   : i_op store op, i_addr_lo byte offset, i_data rt value -> o_wdata, o_be, o_misalign.
module store_lane_fmt
    import dmem_store_unit_pkg::*;
(
    input  logic [1:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_data,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic        o_misalign
);

    always_comb begin
        o_wdata    = 32'h0;
        o_be       = 4'b0000;
        o_misalign = 1'b0;
        case (st_op_e'(i_op))
            ST_SB: begin
                // Replicate the byte so memory only needs the enables to pick the lane.
                o_wdata = {4{i_data[7:0]}};
                o_be    = 4'b0001 << i_addr_lo;
            end
            ST_SH: begin
                o_wdata    = {2{i_data[15:0]}};
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr_lo[0];
            end
            ST_SW: begin
                o_wdata    = i_data;
                o_be       = 4'b1111;
                o_misalign = (i_addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_store_unit.sv
// Purpose : buffers pipeline stores, issues them word-wide to data memory, flags misalign and load hazards.
// Latency : store accepted into an empty buffer in cycle N raises mem_req in cycle N+2; 1 write/cycle with continuous ack.
// Backpressure: st_ready drops when DEPTH entries are held (no same-cycle pop bypass); mem_* held stable until mem_ack.
// Ports   : st_* pipeline store handshake, st_misalign reject pulse, mem_* req/ack write port,
//           ld_check/ld_addr -> ld_hazard word-overlap query, sb_empty buffer drained.
module dmem_store_unit
    import dmem_store_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [1:0]    st_op,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    output logic          st_misalign,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    input  logic          ld_check,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hazard,
    output logic          sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Entry storage: word address plus lane record.
    logic [AW-3:0] r_ent_waddr [DEPTH];
    st_lane_t      r_ent_lane  [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    sb_state_e     r_state;
    logic          r_mem_req;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_be;
    logic          r_misalign;

    logic          w_fmt_mis;
    st_lane_t      w_fmt_lane;
    logic          w_acc;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_bypass;
    logic [CW-1:0] w_count_nxt;
    sb_state_e     w_state_nxt;
    logic [PW-1:0] w_head_ptr;
    logic [AW-3:0] w_head_waddr;
    st_lane_t      w_head_lane;
    logic [PW-1:0] w_scan_idx;
    logic          w_hazard;

    store_lane_fmt u_fmt (
        .i_op       (st_op),
        .i_addr_lo  (st_addr[1:0]),
        .i_data     (st_data),
        .o_wdata    (w_fmt_lane.wdata),
        .o_be       (w_fmt_lane.be),
        .o_misalign (w_fmt_mis)
    );

    assign st_ready = (r_count != CW'(DEPTH));
    assign sb_empty = (r_count == '0);
    // Misaligned stores still complete the handshake; they just never enter the buffer.
    assign w_acc    = st_valid && st_ready && (st_op_e'(st_op) != ST_NONE);
    assign w_push   = w_acc && !w_fmt_mis;
    assign w_pop    = (r_state == ISSUE) && mem_ack;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    if (w_count_nxt != '0) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // When the head pops with a single entry left, the next head is the store
    // being written this same edge, so take it straight from the formatter.
    assign w_head_ptr   = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
    assign w_bypass     = w_pop && (r_count == CW'(1));
    assign w_head_waddr = w_bypass ? st_addr[AW-1:2] : r_ent_waddr[w_head_ptr];
    assign w_head_lane  = w_bypass ? w_fmt_lane      : r_ent_lane[w_head_ptr];

    // Scan the live entries from the head; the in-flight head stays in the
    // buffer until acked, so it is covered too.
    always_comb begin
        w_hazard   = 1'b0;
        w_scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_scan_idx = r_rd_ptr + PW'(i);
            if ((CW'(i) < r_count) && (r_ent_waddr[w_scan_idx] == ld_addr[AW-1:2])) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_check && w_hazard;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ent_waddr[r_wr_ptr] <= st_addr[AW-1:2];
            r_ent_lane[r_wr_ptr]  <= w_fmt_lane;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_misalign <= w_acc && w_fmt_mis;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_load) begin
                r_mem_req   <= 1'b1;
                r_mem_addr  <= {w_head_waddr, 2'b00};
                r_mem_wdata <= w_head_lane.wdata;
                r_mem_be    <= w_head_lane.be;
            end else if (w_pop) begin
                r_mem_req <= 1'b0;
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_be      = r_mem_be;
    assign st_misalign = r_misalign;

endmodule

// File: tb/tb_dmem_store_unit.sv
module tb_dmem_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_misalign;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        sb_empty;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_writes = 0;

    always #5 clk = ~clk;

    dmem_store_unit #(.DEPTH(2), .AW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_op       (st_op),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_misalign (st_misalign),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .ld_check    (ld_check),
        .ld_addr     (ld_addr),
        .ld_hazard   (ld_hazard),
        .sb_empty    (sb_empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_data  = data;
    endtask

    task automatic exp_push(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        e.addr  = addr;
        e.wdata = wdata;
        e.be    = be;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (!sb_empty && g < 20) begin
            tick();
            g++;
        end
        chk(tag, sb_empty, 1);
    endtask

    // Scoreboard: every completed write (req && ack at the coming edge) must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_ack) begin
            n_writes++;
            n_tests++;
            assert (sb_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_write: observed addr %0h expected no write", mem_addr);
            end
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_wdata", mem_wdata, e.wdata);
                chk("wr_be", mem_be, e.be);
            end
        end
    end

    initial begin
        int   guard;
        int   cyc;
        int   w0;
        logic [31:0] d;

        rst = 1'b1; st_valid = 1'b0; st_op = 2'b00; st_addr = '0; st_data = '0;
        mem_ack = 1'b0; ld_check = 1'b1; ld_addr = 32'h0;
        repeat (2) tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_misalign", st_misalign, 0);
        chk("rst_sb_empty", sb_empty, 1);
        chk("rst_st_ready", st_ready, 1);
        chk("rst_ld_hazard", ld_hazard, 0);
        rst = 1'b0;
        ld_check = 1'b0;
        tick();

        // sb to byte 3 of word 0x1000; mem_req appears two edges after accept.
        drive_store(2'b01, 32'h0000_1003, 32'h0000_00A5);
        exp_push(32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
        tick();
        st_valid = 1'b0;
        chk("sb_req_n1", mem_req, 0);
        chk("sb_not_empty", sb_empty, 0);
        tick();
        chk("sb_req_n2", mem_req, 1);
        chk("sb_addr", mem_addr, 32'h0000_1000);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sb_req_drop", mem_req, 0);
        chk("sb_empty_after", sb_empty, 1);

        // sh to upper half.
        drive_store(2'b10, 32'h0000_2002, 32'h0000_1234);
        exp_push(32'h0000_2000, 32'h1234_1234, 4'b1100);
        tick();
        st_valid = 1'b0;
        tick();
        chk("sh_be", mem_be, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;

        // Misaligned sh: one-cycle pulse, nothing enqueued.
        drive_store(2'b10, 32'h0000_2001, 32'h0000_5678);
        chk("mis_before", st_misalign, 0);
        tick();
        st_valid = 1'b0;
        chk("mis_pulse", st_misalign, 1);
        chk("mis_empty", sb_empty, 1);
        tick();
        chk("mis_clear", st_misalign, 0);
        chk("mis_no_req", mem_req, 0);

        // op=00 is ignored entirely.
        drive_store(2'b00, 32'h0000_2003, 32'h0000_0001);
        tick();
        st_valid = 1'b0;
        chk("none_empty", sb_empty, 1);
        chk("none_no_mis", st_misalign, 0);

        // Fill DEPTH=2 with ack held low, third store waits.
        drive_store(2'b11, 32'h0000_4000, 32'h1111_1111);
        exp_push(32'h0000_4000, 32'h1111_1111, 4'hF);
        tick();
        drive_store(2'b11, 32'h0000_4004, 32'h2222_2222);
        exp_push(32'h0000_4004, 32'h2222_2222, 4'hF);
        tick();
        chk("full_ready", st_ready, 0);
        chk("full_req", mem_req, 1);
        chk("full_addr", mem_addr, 32'h0000_4000);
        drive_store(2'b11, 32'h0000_4008, 32'h3333_3333);
        exp_push(32'h0000_4008, 32'h3333_3333, 4'hF);
        tick();
        chk("full_ready_hold", st_ready, 0);
        chk("full_addr_stable", mem_addr, 32'h0000_4000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("pop_ready", st_ready, 1);
        chk("pop_req_high", mem_req, 1);
        chk("pop_next_head", mem_addr, 32'h0000_4004);
        tick();
        st_valid = 1'b0;
        chk("third_accepted", st_ready, 0);
        chk("head_stable", mem_addr, 32'h0000_4004);
        mem_ack = 1'b1;
        tick();
        chk("b2b_addr", mem_addr, 32'h0000_4008);
        chk("b2b_req", mem_req, 1);
        tick();
        mem_ack = 1'b0;
        chk("full_drain_req", mem_req, 0);
        chk("full_drain_empty", sb_empty, 1);

        // Load-after-store hazard.
        drive_store(2'b11, 32'h0000_3000, 32'hDEAD_BEEF);
        exp_push(32'h0000_3000, 32'hDEAD_BEEF, 4'hF);
        tick();
        st_valid = 1'b0;
        ld_check = 1'b1;
        ld_addr  = 32'h0000_3002;
        #1;
        chk("haz_queued", ld_hazard, 1);
        tick();
        chk("haz_inflight", ld_hazard, 1);
        ld_addr = 32'h0000_3004;
        #1;
        chk("haz_other_word", ld_hazard, 0);
        ld_check = 1'b0;
        ld_addr  = 32'h0000_3000;
        #1;
        chk("haz_no_check", ld_hazard, 0);
        ld_check = 1'b1;
        mem_ack  = 1'b1;
        tick();
        mem_ack = 1'b0;
        ld_addr = 32'h0000_3002;
        #1;
        chk("haz_after_ack", ld_hazard, 0);

        // The store accepted this same cycle does not count.
        drive_store(2'b11, 32'h0000_5000, 32'h5555_5555);
        exp_push(32'h0000_5000, 32'h5555_5555, 4'hF);
        ld_addr = 32'h0000_5000;
        #1;
        chk("haz_same_cycle", ld_hazard, 0);
        tick();
        st_valid = 1'b0;
        chk("haz_next_cycle", ld_hazard, 1);
        ld_check = 1'b0;
        mem_ack  = 1'b1;
        drain("haz_drain");
        mem_ack = 1'b0;

        // Streaming with continuous ack: in order, pointer wrap, ~1 write/cycle.
        mem_ack = 1'b1;
        cyc = 0;
        w0  = n_writes;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            drive_store(2'b11, 32'h0000_6000 + 32'(4 * i), d);
            exp_push(32'h0000_6000 + 32'(4 * i), d, 4'hF);
            guard = 0;
            while (!st_ready && guard < 20) begin
                tick();
                cyc++;
                guard++;
            end
            chk("stream_ready_wait", guard < 20, 1);
            tick();
            cyc++;
        end
        st_valid = 1'b0;
        guard = 0;
        while (!sb_empty && guard < 20) begin
            tick();
            cyc++;
            guard++;
        end
        chk("stream_empty", sb_empty, 1);
        chk("stream_writes", n_writes - w0, 8);
        chk("stream_rate", cyc <= 10, 1);
        mem_ack = 1'b0;

        // Reset while a write is in flight with two entries held.
        drive_store(2'b11, 32'h0000_7000, 32'h7777_0000);
        tick();
        drive_store(2'b11, 32'h0000_7004, 32'h7777_0004);
        tick();
        st_valid = 1'b0;
        chk("prerst_req", mem_req, 1);
        chk("prerst_ready", st_ready, 0);
        rst = 1'b1;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_empty", sb_empty, 1);
        chk("midrst_ready", st_ready, 1);
        chk("midrst_be", mem_be, 0);
        tick();
        rst     = 1'b0;
        mem_ack = 1'b1;
        w0      = n_writes;
        repeat (4) tick();
        chk("postrst_req", mem_req, 0);
        chk("postrst_no_write", n_writes - w0, 0);
        mem_ack = 1'b0;

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
